latch_event_reader: RTL



---
 rtl/latch_event_reader.sv | 101 ++++++++++
 1 files changed

// File: rtl/latch_event_reader.sv
// rtl/latch_event_reader.sv - synchronises asynchronous latch outputs and logs each change with a timestamp in a FIFO
// Optional glitch filter: LATCH_READER_GLITCH_FILTER_EN
module latch_event_reader #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         q_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [WIDTH-1:0]         evt_data,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [WIDTH-1:0] s1, s2, prev;
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] cand;
    logic             push;

`ifdef LATCH_READER_GLITCH_FILTER_EN
    logic [WIDTH-1:0] s3;
    // s2 must agree with s3 so a value seen for only one cycle never gets logged
    assign push = (s2 == s3) && (s3 != prev);
    assign cand = s3;
`else
    assign push = (s2 != prev);
    assign cand = s2;
`endif

    logic [WIDTH+TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_next;
    logic                  pop, full, push_ok, drop;

    assign evt_valid = (evt_count != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (evt_count == FULL);
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign rd_next   = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {cand, ts};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
`ifdef LATCH_READER_GLITCH_FILTER_EN
            s3        <= '0;
`endif
            prev      <= '0;
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            evt_data  <= '0;
            evt_ts    <= '0;
            overflow  <= 1'b0;
        end else begin
            s1 <= q_in;
            s2 <= s1;
`ifdef LATCH_READER_GLITCH_FILTER_EN
            s3 <= s2;
`endif
            ts <= ts + 1'b1;
            if (push)
                prev <= cand;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_next;
            case ({push_ok, pop})
                2'b10:   evt_count <= evt_count + ONE;
                2'b01:   evt_count <= evt_count - ONE;
                default: evt_count <= evt_count;
            endcase
            // Head register: the pushed entry becomes head when nothing else remains
            if (push_ok && (evt_count == '0 || (evt_count == ONE && pop)))
                {evt_data, evt_ts} <= {cand, ts};
            else if (pop && evt_count > ONE)
                {evt_data, evt_ts} <= mem[rd_next];
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
